// File: rtl/mul_issuer_if.sv
// Core-side request/response bundle of the multiplier issuer.
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both 1. Once valid is raised, valid and its
// payload stay unchanged until that transfer. Ready may change freely and
// does not depend on valid.
interface mul_issuer_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic [31:0]      req_x;
    logic [31:0]      req_y;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_error;

    // Core side: issues requests, consumes responses
    modport master (
        output req_valid, req_signed, req_x, req_y, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_error
    );

    // Issuer side: accepts requests, produces responses
    modport slave (
        input  req_valid, req_signed, req_x, req_y, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_error
    );
endinterface

// File: rtl/mul_issuer.sv
// Initiator for the iterative multiplier. Requests are queued in a small
// FIFO; the head entry is run on the multiplier until complete (or a timeout),
// then answered on the response channel and popped when that response is taken.
module mul_issuer #(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        mul_clk,
    input  logic        resetn,
    mul_issuer_if.slave core,
    output logic        run,
    output logic        mul_signed,
    output logic [31:0] x,
    output logic [31:0] y,
    input  logic [63:0] result,
    input  logic        complete,
    output logic [1:0]  dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic             sgn;
        logic [31:0]      x;
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_error_q, rsp_error_d;
    logic [63:0]      rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic   fifo_empty;
    logic   fifo_full;
    logic   push;
    logic   pop;
    entry_t head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign push       = core.req_valid && core.req_ready;
    // The head leaves only once its response has been handed over
    assign pop        = (state_q == S_RESP) && core.rsp_ready;
    assign head       = fifo_empty ? '0 : mem_q[rd_ptr_q];

    assign core.req_ready  = resetn && !fifo_full;
    assign core.rsp_valid  = rsp_valid_q;
    assign core.rsp_error  = rsp_error_q;
    assign core.rsp_result = rsp_result_q;
    assign core.rsp_tag    = rsp_tag_q;

    // Operands come straight from the head, which cannot move while running
    assign run        = (state_q == S_RUN);
    assign mul_signed = head.sgn;
    assign x          = head.x;
    assign y          = head.y;
    assign dbg_state  = state_q;

    // FIFO next state: write at tail on push, advance head on pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{sgn: core.req_signed, x: core.req_x,
                                y: core.req_y, tag: core.req_tag};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Issue FSM next state: start on non-empty, finish on complete or timeout
    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_error_d  = rsp_error_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d   = S_RUN;
                    tmo_cnt_d = '0;
                end
            end
            S_RUN: begin
                // complete takes priority over a simultaneous timeout
                if (complete) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_error_d  = 1'b0;
                    rsp_result_d = result;
                    rsp_tag_d    = head.tag;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_error_d  = 1'b1;
                    rsp_result_d = '0;
                    rsp_tag_d    = head.tag;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (core.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers with synchronous active-low reset
    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            tmo_cnt_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge mul_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_mul_issuer.sv
// Bench for mul_issuer: a behavioural multiplier answers run with a scheduled
// latency, and a scoreboard compares every response against expectations.
module tb_mul_issuer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int TMO   = 64;
    localparam int EW    = 1 + TAG_W + 64;

    // ---------------- clock / reset ----------------
    logic mul_clk = 1'b0;
    logic resetn  = 1'b0;
    always #5 mul_clk = ~mul_clk;

    mul_issuer_if #(.TAG_W(TAG_W)) bus ();

    logic        run;
    logic        mul_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] result   = '0;
    logic        complete = 1'b0;
    logic [1:0]  dbg_state;

    mul_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TMO)) dut (
        .mul_clk    (mul_clk),
        .resetn     (resetn),
        .core       (bus),
        .run        (run),
        .mul_signed (mul_signed),
        .x          (x),
        .y          (y),
        .result     (result),
        .complete   (complete),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    int            rdy_mode = 0;
    bit            inject   = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product from plain 64-bit arithmetic
    function automatic logic [63:0] ref_product(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // ---------------- multiplier model + response checker ----------------
    bit          in_op = 0, seen_op = 0, hold_pend = 0;
    int          run_cnt = 0, low_cnt = 0, cur_lat = 0;
    logic        cur_s;
    logic [31:0] cur_x, cur_y;
    logic [EW:0] held;

    always @(negedge mul_clk) begin
        if (!resetn) begin
            lat_q.delete();
            exp_q.delete();
            in_op = 0; seen_op = 0; hold_pend = 0;
            run_cnt = 0; low_cnt = 0;
            complete = 1'b0;
            result = '0;
            bus.rsp_ready = 1'b0;
        end else begin
            if (hold_pend)
                chk("rsp_stable", {bus.rsp_valid, bus.rsp_error, bus.rsp_tag, bus.rsp_result}, held);
            hold_pend = 0;
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
            if (bus.rsp_valid) begin
                if (bus.rsp_ready) begin
                    if (exp_q.size() == 0)
                        chk("rsp_unexpected", bus.rsp_valid, 1'b0);
                    else
                        chk("rsp", {bus.rsp_error, bus.rsp_tag, bus.rsp_result}, exp_q.pop_front());
                end else begin
                    hold_pend = 1;
                    held = {bus.rsp_valid, bus.rsp_error, bus.rsp_tag, bus.rsp_result};
                end
            end
            if (run) begin
                if (!in_op) begin
                    in_op = 1; run_cnt = 0;
                    cur_s = mul_signed; cur_x = x; cur_y = y;
                    if (seen_op) chk("run_gap_ge2", (low_cnt >= 2), 1'b1);
                    if (lat_q.size() == 0) begin
                        chk("run_unexpected", run, 1'b0);
                        cur_lat = 1000;
                    end else begin
                        cur_lat = lat_q[0];
                    end
                end else begin
                    chk("op_stable", {mul_signed, x, y}, {cur_s, cur_x, cur_y});
                end
                complete = (run_cnt == cur_lat) || inject;
                result = complete ? ref_product(mul_signed, x, y) : {$urandom, $urandom};
                run_cnt++;
            end else begin
                if (in_op) begin
                    in_op = 0; seen_op = 1; low_cnt = 0;
                    chk("run_len", run_cnt, (cur_lat <= TMO - 1) ? cur_lat + 1 : TMO);
                    if (lat_q.size() != 0) void'(lat_q.pop_front());
                end
                low_cnt++;
                complete = inject;
                result = {$urandom, $urandom};
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at a negedge with req_valid low
    task automatic push_req(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t, input int lat, input logic [EW-1:0] e);
        int n;
        bus.req_valid  = 1'b1;
        bus.req_signed = s;
        bus.req_x      = a;
        bus.req_y      = b;
        bus.req_tag    = t;
        n = 0;
        while (!bus.req_ready && n < 300) begin
            @(negedge mul_clk);
            n++;
        end
        chk("req_accept", bus.req_ready, 1'b1);
        if (bus.req_ready) begin
            exp_q.push_back(e);
            lat_q.push_back(lat);
        end
        @(negedge mul_clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || run || bus.rsp_valid) && n < 3000) begin
            @(negedge mul_clk);
            n++;
        end
        chk("drain_done", (n < 3000), 1'b1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic             sgn;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        int               lat;
        logic [63:0]      exp_res;
        logic             exp_err;
    } vec_t;

    vec_t vt[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        logic [31:0] a, b;
        int lat, n;
        logic err;

        vt[0] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 4'h1, 2,   64'd15, 1'b0};
        vt[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2, 0,   64'd1, 1'b0};
        vt[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 5,   64'hFFFF_FFFE_0000_0001, 1'b0};
        vt[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 4'h4, 1,   64'h4000_0000_0000_0000, 1'b0};
        vt[4] = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 4'h5, 3,   64'hFFFF_FFFF_FFFF_FFFA, 1'b0};
        vt[5] = '{1'b0, 32'h0000_1234, 32'h0000_5678, 4'h6, 255, 64'd0, 1'b1};
        vt[6] = '{1'b0, 32'h0000_0007, 32'h0000_0009, 4'h7, 0,   64'd63, 1'b0};
        vt[7] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h8, 63,  64'hFFFF_FFFF_FFFF_FFF0, 1'b0};
        vt[8] = '{1'b0, 32'h0000_0002, 32'h0000_0002, 4'h9, 64,  64'd0, 1'b1};

        bus.req_valid = 1'b0; bus.req_signed = 1'b0;
        bus.req_x = '0; bus.req_y = '0; bus.req_tag = '0;

        // reset values
        repeat (3) @(negedge mul_clk);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_run", run, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_error", bus.rsp_error, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, 64'd0);
        chk("rst_rsp_tag", bus.rsp_tag, 4'd0);
        resetn = 1'b1;
        @(negedge mul_clk);
        chk("idle_req_ready", bus.req_ready, 1'b1);
        chk("idle_x", x, 32'd0);
        chk("idle_y", y, 32'd0);
        chk("idle_signed", mul_signed, 1'b0);

        // table: single operations including timeout boundaries
        rdy_mode = 0;
        for (int i = 0; i < 9; i++) begin
            push_req(vt[i].sgn, vt[i].a, vt[i].b, vt[i].tag, vt[i].lat,
                     {vt[i].exp_err, vt[i].tag, vt[i].exp_res});
            wait_drain();
        end

        // FIFO fills with responses blocked, then drains in order
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            push_req(1'b0, a, b, TAG_W'(i + 10), 1, {1'b0, TAG_W'(i + 10), ref_product(1'b0, a, b)});
        end
        chk("full_req_ready", bus.req_ready, 1'b0);
        rdy_mode = 0;
        push_req(1'b1, 32'hFFFF_FFF0, 32'h0000_0100, 4'hE, 2,
                 {1'b0, 4'hE, 64'hFFFF_FFFF_FFFF_F000});
        wait_drain();

        // response held off: outputs stable, nothing new issued
        rdy_mode = 2;
        push_req(1'b0, 32'd100, 32'd200, 4'h3, 2, {1'b0, 4'h3, 64'd20000});
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge mul_clk);
            n++;
        end
        chk("hold_rsp_seen", bus.rsp_valid, 1'b1);
        push_req(1'b0, 32'd6, 32'd7, 4'h4, 0, {1'b0, 4'h4, 64'd42});
        for (int i = 0; i < 10; i++) begin
            @(negedge mul_clk);
            chk("hold_run_low", run, 1'b0);
        end
        rdy_mode = 0;
        wait_drain();

        // reset in the middle of a run; a late complete must be ignored
        push_req(1'b0, 32'd5, 32'd5, 4'h5, 255, {1'b0, 4'h5, 64'd25});
        n = 0;
        while (!run && n < 100) begin
            @(negedge mul_clk);
            n++;
        end
        chk("mid_run_seen", run, 1'b1);
        repeat (5) @(negedge mul_clk);
        resetn = 1'b0;
        @(negedge mul_clk);
        chk("mid_rst_run", run, 1'b0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_req_ready", bus.req_ready, 1'b0);
        @(negedge mul_clk);
        resetn = 1'b1;
        @(negedge mul_clk);
        chk("post_rst_req_ready", bus.req_ready, 1'b1);
        chk("post_rst_x", x, 32'd0);
        @(posedge mul_clk); #1 inject = 1'b1;
        @(posedge mul_clk); #1 inject = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge mul_clk);
            chk("late_cpl_run", run, 1'b0);
            chk("late_cpl_rsp_valid", bus.rsp_valid, 1'b0);
        end
        push_req(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 4'h6, 3, {1'b0, 4'h6, 64'd9});
        wait_drain();

        // randomized traffic against the reference model
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 4) == 0) b = 32'hFFFF_FFFF;
            n = $urandom_range(0, 19);
            if (n < 16)       lat = $urandom_range(0, 6);
            else if (n == 16) lat = TMO - 1;
            else if (n == 17) lat = TMO;
            else              lat = 200;
            err = (lat > TMO - 1);
            push_req(s, a, b, TAG_W'(i), lat,
                     {err, TAG_W'(i), err ? 64'd0 : ref_product(s, a, b)});
            repeat ($urandom_range(0, 3)) @(negedge mul_clk);
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
